// File: rtl/video_source.sv
// Raster video source: sync/de timing with fixed porches, active region filled
// from a built-in test pattern or an external pixel supplier.
module video_source #(
    parameter int H_SIZE = 83,
    parameter int V_SIZE = 64,
    parameter int H_FP   = 4,
    parameter int H_SYNC = 8,
    parameter int H_BP   = 8,
    parameter int V_FP   = 2,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [1:0] mode,
    input  logic [7:0] ext_pixel,
    output logic       ext_req,
    output logic [7:0] out_image,
    output logic       out_de,
    output logic       out_hsync,
    output logic       out_vsync,
    output logic       frame_start
);

    localparam logic [9:0] H_ACT  = 10'(H_SIZE);
    localparam logic [9:0] HS_BEG = 10'(H_SIZE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_SIZE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST = 10'(H_SIZE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_ACT  = 10'(V_SIZE);
    localparam logic [9:0] VS_BEG = 10'(V_SIZE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_SIZE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST = 10'(V_SIZE + V_FP + V_SYNC + V_BP - 1);

    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic [1:0] mode_q, mode_d;
    logic [7:0] image_q, image_d;
    logic       de_q, hsync_q, vsync_q, fs_q;

    logic       origin_s, active_s, hsync_s, vsync_s;
    logic [1:0] eff_mode_s;
    logic [7:0] pattern_s;

    // Raster counters: hcnt wraps each line, vcnt wraps each frame.
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (ce) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = 10'd0;
                if (vcnt_q == V_LAST) begin
                    vcnt_d = 10'd0;
                end else begin
                    vcnt_d = vcnt_q + 10'd1;
                end
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
        end else begin
            hcnt_d = hcnt_q;
            vcnt_d = vcnt_q;
        end
    end

    // Region decode, pattern select and external request.
    always_comb begin
        origin_s   = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
        active_s   = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        hsync_s    = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
        vsync_s    = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
        // The first pixel of a frame already uses the mode being latched now.
        eff_mode_s = origin_s ? mode : mode_q;
        mode_d     = (ce && origin_s) ? mode : mode_q;
        case (eff_mode_s)
            2'd0:    pattern_s = hcnt_q[7:0];
            2'd1:    pattern_s = vcnt_q[7:0];
            2'd2:    pattern_s = (hcnt_q[3] ^ vcnt_q[3]) ? 8'hFF : 8'h00;
            2'd3:    pattern_s = ext_pixel;
            default: pattern_s = 8'h00;
        endcase
        if (active_s) begin
            image_d = pattern_s;
        end else begin
            image_d = 8'h00;
        end
        ext_req = rst & ce & active_s & (eff_mode_s == 2'd3);
    end

    // State and output registers; ce low freezes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt_q  <= 10'd0;
            vcnt_q  <= 10'd0;
            mode_q  <= 2'd0;
            image_q <= 8'h00;
            de_q    <= 1'b0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            fs_q    <= 1'b0;
        end else if (ce) begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            mode_q  <= mode_d;
            image_q <= image_d;
            de_q    <= active_s;
            hsync_q <= hsync_s;
            vsync_q <= vsync_s;
            fs_q    <= origin_s;
        end
    end

    assign out_image   = image_q;
    assign out_de      = de_q;
    assign out_hsync   = hsync_q;
    assign out_vsync   = vsync_q;
    assign frame_start = fs_q;

endmodule
